// File: rtl/ucsbece154b_fifo_status.sv
// First-word-fall-through FIFO with fill count, almost-full, flush and sticky error flags.
// Pointers wrap by explicit compare, so the depth need not be a power of two.
module ucsbece154b_fifo_status #(
  parameter int DATA_WIDTH = 32,
  parameter int NR_ENTRIES = 4,
  parameter int AF_THRESH  = NR_ENTRIES - 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                clear_err_i,
  input  logic [DATA_WIDTH-1:0]               data_i,
  input  logic                                push_i,
  input  logic                                pop_i,
  output logic [DATA_WIDTH-1:0]               data_o,
  output logic                                valid_o,
  output logic                                full_o,
  output logic                                almost_full_o,
  output logic [$clog2(NR_ENTRIES+1)-1:0]     count_o,
  output logic                                overflow_o,
  output logic                                underflow_o
);

  localparam int CW = $clog2(NR_ENTRIES + 1);
  localparam int PW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

  logic [DATA_WIDTH-1:0] r_mem [NR_ENTRIES];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_valid;
  logic w_full;
  logic w_popAcc;
  logic w_pushAcc;
  logic w_setOverflow;
  logic w_setUnderflow;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    nextPtr = (ptr == PW'(NR_ENTRIES - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_valid        = (r_count != '0);
  assign w_full         = (r_count == CW'(NR_ENTRIES));
  assign w_popAcc       = pop_i & w_valid;
  assign w_pushAcc      = push_i & (~w_full | w_popAcc);
  assign w_setOverflow  = push_i & ~w_pushAcc & ~flush_i;
  assign w_setUnderflow = pop_i & ~w_valid & ~flush_i;

  assign valid_o       = w_valid;
  assign full_o        = w_full;
  assign almost_full_o = (r_count >= CW'(AF_THRESH));
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;
  assign underflow_o   = r_underflow;
  assign data_o        = w_valid ? r_mem[r_head] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && w_pushAcc) begin
      r_mem[r_tail] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_popAcc) begin
        r_head <= nextPtr(r_head);
      end
      if (w_pushAcc) begin
        r_tail <= nextPtr(r_tail);
      end
      r_count <= r_count + CW'(w_pushAcc) - CW'(w_popAcc);
    end
  end

  // Setting a flag takes precedence over clearing it in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_setOverflow) begin
        r_overflow <= 1'b1;
      end else if (clear_err_i) begin
        r_overflow <= 1'b0;
      end
      if (w_setUnderflow) begin
        r_underflow <= 1'b1;
      end else if (clear_err_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154b_fifo_status.sv
// Bench for ucsbece154b_fifo_status: directed vector table, wrap-around sequence and
// randomized traffic checked against a queue-based reference model.
module tb_ucsbece154b_fifo_status;

  logic        clk;
  logic        rst, flush, clr, push, pop;
  logic [31:0] dIn;
  logic [31:0] dOut;
  logic        valid, full, almostFull, overflow, underflow;
  logic [2:0]  count;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [31:0] mq[$];
  bit          mOv;
  bit          mUn;

  typedef struct {
    logic        rst, flush, clr, push, pop;
    logic [31:0] data;
    int          cnt;
    logic        v, f, af;
    logic [31:0] d;
    logic        ov, un;
  } vec_t;

  vec_t vecs[$];

  ucsbece154b_fifo_status #(
    .DATA_WIDTH(32),
    .NR_ENTRIES(4),
    .AF_THRESH (3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .clear_err_i  (clr),
    .data_i       (dIn),
    .push_i       (push),
    .pop_i        (pop),
    .data_o       (dOut),
    .valid_o      (valid),
    .full_o       (full),
    .almost_full_o(almostFull),
    .count_o      (count),
    .overflow_o   (overflow),
    .underflow_o  (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of stored words plus two sticky bits.
  task automatic modelStep(input logic r, input logic fl, input logic c,
                           input logic pu, input logic po, input logic [31:0] d);
    bit popOk, pushOk, setOv, setUn;
    if (r) begin
      mq.delete();
      mOv = 0;
      mUn = 0;
    end else if (fl) begin
      mq.delete();
      if (c) begin
        mOv = 0;
        mUn = 0;
      end
    end else begin
      popOk  = po && (mq.size() > 0);
      pushOk = pu && ((mq.size() < 4) || popOk);
      setOv  = pu && !pushOk;
      setUn  = po && (mq.size() == 0);
      if (popOk) void'(mq.pop_front());
      if (pushOk) mq.push_back(d);
      if (setOv) mOv = 1; else if (c) mOv = 0;
      if (setUn) mUn = 1; else if (c) mUn = 0;
    end
  endtask

  // Drive on the negedge, let the posedge happen, return on the following negedge.
  task automatic applyStimulus(input logic r, input logic fl, input logic c,
                               input logic pu, input logic po, input logic [31:0] d);
    rst   = r;
    flush = fl;
    clr   = c;
    push  = pu;
    pop   = po;
    dIn   = d;
    modelStep(r, fl, c, pu, po, d);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".count"},     32'(count),      32'(mq.size()));
    check({tag, ".valid"},     32'(valid),      32'(mq.size() != 0));
    check({tag, ".full"},      32'(full),       32'(mq.size() == 4));
    check({tag, ".almostFull"},32'(almostFull), 32'(mq.size() >= 3));
    check({tag, ".data"},      dOut,            (mq.size() != 0) ? mq[0] : 32'h0);
    check({tag, ".overflow"},  32'(overflow),   32'(mOv));
    check({tag, ".underflow"}, 32'(underflow),  32'(mUn));
  endtask

  function automatic void addVec(input logic r, input logic fl, input logic c,
                                 input logic pu, input logic po, input logic [31:0] data,
                                 input int cnt, input logic v, input logic f, input logic af,
                                 input logic [31:0] d, input logic ov, input logic un);
    vec_t t;
    t.rst = r; t.flush = fl; t.clr = c; t.push = pu; t.pop = po; t.data = data;
    t.cnt = cnt; t.v = v; t.f = f; t.af = af; t.d = d; t.ov = ov; t.un = un;
    vecs.push_back(t);
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; dIn = '0;

    //      rst fl clr pu po data           cnt v f af d              ov un
    addVec(1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         0, 0);
    addVec(0, 0, 0, 1, 0, 32'h11111111,  1, 1, 0, 0, 32'h11111111,  0, 0);
    addVec(0, 0, 0, 1, 0, 32'h22222222,  2, 1, 0, 0, 32'h11111111,  0, 0);
    addVec(0, 0, 0, 1, 0, 32'h33333333,  3, 1, 0, 1, 32'h11111111,  0, 0);
    addVec(0, 0, 0, 1, 0, 32'h44444444,  4, 1, 1, 1, 32'h11111111,  0, 0);
    addVec(0, 0, 0, 1, 0, 32'h55555555,  4, 1, 1, 1, 32'h11111111,  1, 0);
    addVec(0, 0, 0, 0, 1, 32'h0,         3, 1, 0, 1, 32'h22222222,  1, 0);
    addVec(0, 0, 0, 0, 1, 32'h0,         2, 1, 0, 0, 32'h33333333,  1, 0);
    addVec(0, 0, 0, 0, 1, 32'h0,         1, 1, 0, 0, 32'h44444444,  1, 0);
    addVec(0, 0, 0, 0, 1, 32'h0,         0, 0, 0, 0, 32'h0,         1, 0);
    addVec(0, 0, 0, 0, 1, 32'h0,         0, 0, 0, 0, 32'h0,         1, 1);
    addVec(0, 0, 1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         0, 0);
    addVec(0, 0, 0, 1, 0, 32'h11111111,  1, 1, 0, 0, 32'h11111111,  0, 0);
    addVec(0, 0, 0, 1, 0, 32'h22222222,  2, 1, 0, 0, 32'h11111111,  0, 0);
    addVec(0, 0, 0, 1, 0, 32'h33333333,  3, 1, 0, 1, 32'h11111111,  0, 0);
    addVec(0, 0, 0, 1, 0, 32'h44444444,  4, 1, 1, 1, 32'h11111111,  0, 0);
    addVec(0, 0, 0, 1, 1, 32'hAAAAAAAA,  4, 1, 1, 1, 32'h22222222,  0, 0);
    addVec(0, 0, 0, 0, 1, 32'h0,         3, 1, 0, 1, 32'h33333333,  0, 0);
    addVec(0, 0, 0, 0, 1, 32'h0,         2, 1, 0, 0, 32'h44444444,  0, 0);
    addVec(0, 0, 0, 0, 1, 32'h0,         1, 1, 0, 0, 32'hAAAAAAAA,  0, 0);
    addVec(0, 0, 0, 0, 1, 32'h0,         0, 0, 0, 0, 32'h0,         0, 0);
    addVec(0, 0, 0, 1, 1, 32'h0000005A,  1, 1, 0, 0, 32'h0000005A,  0, 1);
    addVec(0, 0, 1, 0, 1, 32'h0,         0, 0, 0, 0, 32'h0,         0, 0);
    addVec(0, 0, 1, 0, 1, 32'h0,         0, 0, 0, 0, 32'h0,         0, 1);
    addVec(0, 0, 0, 1, 0, 32'h00000001,  1, 1, 0, 0, 32'h00000001,  0, 1);
    addVec(0, 0, 0, 1, 0, 32'h00000002,  2, 1, 0, 0, 32'h00000001,  0, 1);
    addVec(0, 0, 0, 1, 0, 32'h00000003,  3, 1, 0, 1, 32'h00000001,  0, 1);
    addVec(0, 1, 0, 1, 0, 32'h00000009,  0, 0, 0, 0, 32'h0,         0, 1);
    addVec(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         0, 1);

    @(negedge clk);
    $display("[TB] directed vector table");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].clr,
                    vecs[i].push, vecs[i].pop, vecs[i].data);
      check($sformatf("vec%0d.count", i),     32'(count),      32'(vecs[i].cnt));
      check($sformatf("vec%0d.valid", i),     32'(valid),      32'(vecs[i].v));
      check($sformatf("vec%0d.full", i),      32'(full),       32'(vecs[i].f));
      check($sformatf("vec%0d.almostFull", i),32'(almostFull), 32'(vecs[i].af));
      check($sformatf("vec%0d.data", i),      dOut,            vecs[i].d);
      check($sformatf("vec%0d.overflow", i),  32'(overflow),   32'(vecs[i].ov));
      check($sformatf("vec%0d.underflow", i), 32'(underflow),  32'(vecs[i].un));
    end

    $display("[TB] wrap-around sequence");
    applyStimulus(0, 0, 1, 0, 0, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 32'(k));
      check($sformatf("wrap%0d.head", k), dOut, 32'(k));
      check($sformatf("wrap%0d.countMax", k), 32'(count <= 3'd1), 32'd1);
      applyStimulus(0, 0, 0, 0, 1, 32'h0);
      check($sformatf("wrap%0d.emptyAfterPop", k), 32'(valid), 32'd0);
    end
    checkOutput("wrapEnd");

    $display("[TB] randomized traffic");
    for (int n = 0; n < 500; n++) begin
      applyStimulus(($urandom_range(63) == 0),
                    ($urandom_range(15) == 0),
                    ($urandom_range(7) == 0),
                    ($urandom_range(99) < 60),
                    ($urandom_range(99) < 50),
                    $urandom);
      checkOutput($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
